// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited in-order fetch to imem, and a
// small {instr, pc} FIFO toward the decoder with redirect/squash support.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

  fq_entry_t       fq  [DEPTH];
  logic [31:0]     pcq [DEPTH];
  logic [PW-1:0]   rptr, wptr, qrptr, qwptr;
  logic [CW-1:0]   count, outstanding, discard, out_nxt;
  logic [CW:0]     fill;
  logic [31:0]     pc;
  logic            started;
  logic            grant, rsp, drop, push, pop;
  logic            unused_rpc;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit counts both buffered and in-flight words, so every response has a slot.
  assign fill      = {1'b0, count} + {1'b0, outstanding};
  assign imem_req  = started && (fill < (CW+1)'(DEPTH));
  assign imem_addr = pc;

  assign grant   = imem_req && imem_gnt;
  assign rsp     = imem_rvalid && (outstanding != '0);
  assign drop    = discard != '0;
  assign push    = rsp && !drop && !redirect_valid;
  assign pop     = instr_valid && instr_ready && !redirect_valid;
  assign out_nxt = outstanding + CW'(grant) - CW'(rsp);

  assign instr_valid = count != '0;
  assign instr       = fq[rptr].instr;
  assign instr_pc    = fq[rptr].pc;

  assign unused_rpc = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      started     <= 1'b0;
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rptr        <= '0;
      wptr        <= '0;
      qrptr       <= '0;
      qwptr       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fq[i]  <= '0;
        pcq[i] <= '0;
      end
    end else begin
      started     <= 1'b1;
      outstanding <= out_nxt;
      // PC queue follows every grant/response, squashed or not, to stay aligned.
      if (grant) begin
        pcq[qwptr] <= pc;
        qwptr      <= inc(qwptr);
      end
      if (rsp) qrptr <= inc(qrptr);

      if (redirect_valid) begin
        pc    <= {redirect_pc[31:2], 2'b00};
        count <= '0;
        rptr  <= '0;
        wptr  <= '0;
        // After a redirect every in-flight word is stale, including ones already
        // marked for discard, so discard becomes the new in-flight count.
        discard <= out_nxt;
      end else begin
        if (grant)        pc      <= pc + 32'd4;
        if (rsp && drop)  discard <= discard - 1'b1;
        if (push) begin
          fq[wptr] <= '{instr: imem_rdata, pc: pcq[qrptr]};
          wptr     <= inc(wptr);
        end
        if (pop) rptr <= inc(rptr);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: DEPTH=2 instance with a latency-modelled memory
// and an in-order scoreboard, plus a DEPTH=4 wrap-PC instance driven by hand.
module tb_fetch_unit;
  logic        clk, resetn;
  logic        imem_req, imem_gnt, imem_rvalid, redirect_valid, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
  logic        req2, g2, rv2, rdr2, iv2, rdy2;
  logic [31:0] addr2, rd2, rpc2, ins2, ipc2;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, lat = 1, npop = 0;
  logic gnt_en = 0, rdy = 0;
  logic [31:0] exp_pc = 0;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) u_dut (
    .clk(clk), .resetn(resetn), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready));

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .imem_req(req2), .imem_addr(addr2),
    .imem_gnt(g2), .imem_rvalid(rv2), .imem_rdata(rd2),
    .redirect_valid(rdr2), .redirect_pc(rpc2),
    .instr_valid(iv2), .instr(ins2), .instr_pc(ipc2), .instr_ready(rdy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle of the DEPTH=2 instance, evaluated at the negedge.
  task automatic cycle();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0].addr ^ 32'hA5A5_0000;
      void'(mq.pop_front());
    end
    imem_gnt    = gnt_en;
    instr_ready = rdy;
    if (imem_req && imem_gnt) mq.push_back('{imem_addr, cyc + lat});
    if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    else if (instr_valid && instr_ready) begin
      chk("pop_pc", instr_pc, exp_pc);
      chk("pop_instr", instr, exp_pc ^ 32'hA5A5_0000);
      exp_pc += 4;
      npop++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    g2 = 1'b0; rv2 = 1'b0; rd2 = 32'h0; rdr2 = 1'b0; rpc2 = 32'h0; rdy2 = 1'b0;
    gnt_en = 1'b0; rdy = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ipc", instr_pc, 32'h0);
    chk("rst_addr2", addr2, 32'hFFFF_FFFC);
    mq.delete();
    exp_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    cyc = 0;
  endtask

  initial begin
    int n, n0;
    resetn = 1'b0;
    @(negedge clk);

    // Sequential fetch, 1-cycle memory
    do_reset();
    lat = 1; gnt_en = 1; rdy = 1;
    chk("seq_req0", imem_req, 1);
    chk("seq_addr0", imem_addr, 32'h0);
    cycle();
    chk("seq_v1", instr_valid, 0);
    cycle();
    chk("seq_v2", instr_valid, 1);
    chk("seq_pc2", instr_pc, 32'h0);
    repeat (10) cycle();

    // Grant stall at 0x10
    do_reset();
    lat = 1; gnt_en = 1; rdy = 1;
    n = 0;
    while (!(imem_req && imem_addr == 32'h10) && n < 20) begin cycle(); n++; end
    chk("stall_reach", imem_addr, 32'h10);
    gnt_en = 0;
    repeat (3) begin
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, 32'h10);
      cycle();
    end
    gnt_en = 1;
    repeat (6) cycle();

    // Backpressure
    rdy = 0;
    repeat (10) cycle();
    chk("bp_req", imem_req, 0);
    chk("bp_valid", instr_valid, 1);
    chk("bp_inflight", 32'(mq.size()), 0);
    rdy = 1;
    n0 = npop;
    repeat (12) cycle();
    chk("bp_resume", 32'(npop - n0 >= 4), 1);

    // Redirect with two in-flight fetches, 3-cycle memory
    do_reset();
    lat = 3; gnt_en = 1; rdy = 1;
    n = 0;
    while (imem_req && n < 10) begin cycle(); n++; end
    chk("rd_inflight", 32'(mq.size()), 2);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    cycle();
    redirect_valid = 1'b0;
    chk("rd_empty", instr_valid, 0);
    n = 0;
    while (!instr_valid && n < 20) begin cycle(); n++; end
    chk("rd_first_valid", instr_valid, 1);
    chk("rd_first_pc", instr_pc, 32'h100);
    repeat (10) cycle();

    // DEPTH=4 instance: PC wrap, then redirect with same-cycle grant/rvalid/pop
    do_reset();
    chk("wr_req0", req2, 1);
    chk("wr_addr0", addr2, 32'hFFFF_FFFC);
    g2 = 1; @(negedge clk);
    chk("wr_addr1", addr2, 32'h0000_0000);
    g2 = 1; rv2 = 1; rd2 = 32'h1111_0000; @(negedge clk);
    chk("sim_v_pre", iv2, 1);
    chk("sim_pc_pre", ipc2, 32'hFFFF_FFFC);
    chk("sim_ins_pre", ins2, 32'h1111_0000);
    chk("sim_req_pre", req2, 1);
    g2 = 1; rv2 = 1; rd2 = 32'h2222_0000; rdy2 = 1; rdr2 = 1; rpc2 = 32'h0000_0202;
    @(negedge clk);
    rdr2 = 0;
    chk("sim_v_n1", iv2, 0);
    chk("sim_req_n1", req2, 1);
    chk("sim_addr_n1", addr2, 32'h0000_0200);
    g2 = 1; rv2 = 1; rd2 = 32'h3333_0000; @(negedge clk);
    chk("sim_stale", iv2, 0);
    chk("sim_addr_n2", addr2, 32'h0000_0204);
    g2 = 0; rv2 = 1; rd2 = 32'h4444_0200; @(negedge clk);
    rv2 = 0;
    chk("sim_new_v", iv2, 1);
    chk("sim_new_pc", ipc2, 32'h0000_0200);
    chk("sim_new_ins", ins2, 32'h4444_0200);
    @(negedge clk);
    chk("sim_popped", iv2, 0);
    rv2 = 1; rd2 = 32'hDEAD_BEEF; @(negedge clk);
    rv2 = 0;
    chk("proto_err_v", iv2, 0);
    chk("proto_err_req", req2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
